// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes,
// FSM state encoding and small funct-decode helpers.
package hilo_muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    // True for the four funct codes that start a multi-cycle operation.
    function automatic logic is_muldiv_funct(input logic [5:0] funct);
        logic hit;
        case (funct)
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: hit = 1'b1;
            default:                                        hit = 1'b0;
        endcase
        return hit;
    endfunction

    // True for div/divu.
    function automatic logic is_div_funct(input logic [5:0] funct);
        return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    endfunction

    // True for the signed variants mult/div.
    function automatic logic is_signed_funct(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one
// bit per step. The hi/lo accumulator pair is shared by both operations:
// multiply keeps {partial product, multiplier}, divide keeps
// {partial remainder, dividend/quotient}.
module muldiv_iter_core
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo,
    output logic             last_iter
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] opnd_r;
    logic             is_div_r;
    logic [CW-1:0]    count_r;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH+1:0] div_diff_s;
    logic [WIDTH-1:0] hi_next_s;
    logic [WIDTH-1:0] lo_next_s;

    // One iteration of either algorithm, selected by the latched op.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {hi_r, lo_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_r};
        hi_next_s   = hi_r;
        lo_next_s   = lo_r;
        if (is_div_r) begin
            if (div_diff_s[WIDTH+1]) begin
                hi_next_s = div_shift_s[WIDTH-1:0];
                lo_next_s = {lo_r[WIDTH-2:0], 1'b0};
            end else begin
                hi_next_s = div_diff_s[WIDTH-1:0];
                lo_next_s = {lo_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            hi_next_s = mul_sum_s[WIDTH:1];
            lo_next_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    // Operand latch on load, then one accumulator update per step.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            count_r  <= {CW{1'b0}};
        end else if (load) begin
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= is_div ? op_a : op_b;
            opnd_r   <= is_div ? op_b : op_a;
            is_div_r <= is_div;
            count_r  <= {CW{1'b0}};
        end else if (step) begin
            hi_r    <= hi_next_s;
            lo_r    <= lo_next_s;
            count_r <= count_r + CW'(1);
        end
    end

    assign acc_hi    = hi_r;
    assign acc_lo    = lo_r;
    assign last_iter = step && (count_r == CW'(WIDTH-1));

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Owns the IDLE/CALC/FIX sequencing, sign handling and mthi/mtlo writes;
// the unsigned iteration lives in muldiv_iter_core.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Start,
    input  logic [5:0]       Function_opcode,
    input  logic [WIDTH-1:0] Read_data_1,
    input  logic [WIDTH-1:0] Read_data_2,
    input  logic             Mthi,
    input  logic             Mtlo,
    output logic [WIDTH-1:0] Hi_out,
    output logic [WIDTH-1:0] Lo_out,
    output logic             Busy,
    output logic             Done
);

    // Two's-complement negate of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Two's-complement negate of a 2*WIDTH-bit value.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    md_state_e        state_r;
    md_state_e        state_next_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             is_div_r;
    logic             div0_r;
    logic             neg_q_r;
    logic             neg_rem_r;
    logic [WIDTH-1:0] dividend_r;

    logic             start_ok_s;
    logic             op_div_s;
    logic             op_signed_s;
    logic             sign_a_s;
    logic             sign_b_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic             step_s;

    logic [WIDTH-1:0]   core_hi_s;
    logic [WIDTH-1:0]   core_lo_s;
    logic               core_last_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    assign start_ok_s  = (state_r == ST_IDLE) && Start && is_muldiv_funct(Function_opcode);
    assign op_div_s    = is_div_funct(Function_opcode);
    assign op_signed_s = is_signed_funct(Function_opcode);
    assign sign_a_s    = op_signed_s && Read_data_1[WIDTH-1];
    assign sign_b_s    = op_signed_s && Read_data_2[WIDTH-1];
    assign mag_a_s     = sign_a_s ? neg_w(Read_data_1) : Read_data_1;
    assign mag_b_s     = sign_b_s ? neg_w(Read_data_2) : Read_data_2;
    assign step_s      = (state_r == ST_CALC);

    muldiv_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock     (clock),
        .reset     (reset),
        .load      (start_ok_s),
        .step      (step_s),
        .is_div    (op_div_s),
        .op_a      (mag_a_s),
        .op_b      (mag_b_s),
        .acc_hi    (core_hi_s),
        .acc_lo    (core_lo_s),
        .last_iter (core_last_s)
    );

    // Next-state decode; a divide by zero skips the iterations entirely.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    if (op_div_s && (Read_data_2 == {WIDTH{1'b0}})) begin
                        state_next_s = ST_FIX;
                    end else begin
                        state_next_s = ST_CALC;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (core_last_s) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_FIX:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Sign correction of the unsigned core result into final HI/LO values.
    always_comb begin
        prod_s   = {core_hi_s, core_lo_s};
        res_hi_s = core_hi_s;
        res_lo_s = core_lo_s;
        if (div0_r) begin
            res_hi_s = dividend_r;
            res_lo_s = {WIDTH{1'b1}};
        end else if (is_div_r) begin
            res_lo_s = neg_q_r   ? neg_w(core_lo_s) : core_lo_s;
            res_hi_s = neg_rem_r ? neg_w(core_hi_s) : core_hi_s;
        end else begin
            if (neg_q_r) begin
                prod_s = neg_2w({core_hi_s, core_lo_s});
            end else begin
                prod_s = {core_hi_s, core_lo_s};
            end
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // State register with registered Busy/Done flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_r == ST_FIX);
        end
    end

    // Latch operation kind and result-sign flags when a Start is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            is_div_r   <= 1'b0;
            div0_r     <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_rem_r  <= 1'b0;
            dividend_r <= {WIDTH{1'b0}};
        end else if (start_ok_s) begin
            is_div_r   <= op_div_s;
            div0_r     <= op_div_s && (Read_data_2 == {WIDTH{1'b0}});
            neg_q_r    <= sign_a_s ^ sign_b_s;
            neg_rem_r  <= sign_a_s;
            dividend_r <= Read_data_1;
        end
    end

    // Architectural HI/LO: written in FIX, or by mthi/mtlo while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (state_r == ST_FIX) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else if ((state_r == ST_IDLE) && !start_ok_s) begin
            if (Mthi) begin
                hi_r <= Read_data_1;
            end
            if (Mtlo) begin
                lo_r <= Read_data_1;
            end
        end
    end

    assign Hi_out = hi_r;
    assign Lo_out = lo_r;
    assign Busy   = busy_r;
    assign Done   = done_r;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: a table of mult/div vectors with
// hand-computed results plus directed sequences for mt*, ignored starts
// and reset abort. Edge counting treats the Start-sampling edge as edge 1,
// so a normal op completes on edge 34 and a divide by zero on edge 2.
module tb_hilo_muldiv;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MFHI  = 6'h10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [5:0]  Function_opcode = 6'h00;
    logic [31:0] Read_data_1 = 32'h0;
    logic [31:0] Read_data_2 = 32'h0;
    logic        Mthi = 1'b0;
    logic        Mtlo = 1'b0;
    logic [31:0] Hi_out;
    logic [31:0] Lo_out;
    logic        Busy;
    logic        Done;

    int tests  = 0;
    int failed = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .Start           (Start),
        .Function_opcode (Function_opcode),
        .Read_data_1     (Read_data_1),
        .Read_data_2     (Read_data_2),
        .Mthi            (Mthi),
        .Mtlo            (Mtlo),
        .Hi_out          (Hi_out),
        .Lo_out          (Lo_out),
        .Busy            (Busy),
        .Done            (Done)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and follow it edge by edge to completion.
    task automatic run_op(input vec_t v);
        int bad;
        bad = 0;
        Function_opcode = v.funct;
        Read_data_1 = v.a;
        Read_data_2 = v.b;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int n = 1; n < v.lat; n++) begin
            if (!(Busy === 1'b1 && Done === 1'b0 && Hi_out === m_hi && Lo_out === m_lo))
                bad++;
            tick();
        end
        check({v.name, " busy_window_errors"}, 32'(bad), 32'd0);
        check({v.name, " done"}, {31'd0, Done}, 32'd1);
        check({v.name, " busy_end"}, {31'd0, Busy}, 32'd0);
        check({v.name, " hi"}, Hi_out, v.exp_hi);
        check({v.name, " lo"}, Lo_out, v.exp_lo);
        m_hi = v.exp_hi;
        m_lo = v.exp_lo;
        tick();
        check({v.name, " done_pulse_end"}, {31'd0, Done}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"multu_max",   F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34};
        vecs[1]  = '{"mult_m3x7",   F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 34};
        vecs[2]  = '{"divu_100_7",  F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       34};
        vecs[3]  = '{"div_m7_2",    F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34};
        vecs[4]  = '{"div_7_m2",    F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34};
        vecs[5]  = '{"div_ovf",     F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
        vecs[6]  = '{"mult_min_sq", F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34};
        vecs[7]  = '{"multu_shift", F_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 34};
        vecs[8]  = '{"divu_by1",    F_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 34};
        vecs[9]  = '{"divu_small",  F_DIVU,  32'd5,        32'd10,       32'd5,        32'd0,        34};
        vecs[10] = '{"mult_m1_m1",  F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 34};
        vecs[11] = '{"div_m100_7",  F_DIV,   32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2, 34};
        vecs[12] = '{"div_by0",     F_DIV,   32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 2};
        vecs[13] = '{"divu_by0",    F_DIVU,  32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 2};
        vecs[14] = '{"div_neg_by0", F_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 2};

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("reset_hi", Hi_out, 32'h0);
        check("reset_lo", Lo_out, 32'h0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);

        // mthi then mtlo in IDLE
        Read_data_1 = 32'hAAAA5555;
        Mthi = 1'b1;
        tick();
        Mthi = 1'b0;
        check("mthi_hi", Hi_out, 32'hAAAA5555);
        check("mthi_lo_kept", Lo_out, 32'h0);
        Read_data_1 = 32'h5555AAAA;
        Mtlo = 1'b1;
        tick();
        Mtlo = 1'b0;
        check("mtlo_lo", Lo_out, 32'h5555AAAA);
        check("mtlo_hi_kept", Hi_out, 32'hAAAA5555);
        m_hi = 32'hAAAA5555;
        m_lo = 32'h5555AAAA;

        // Start with a non-muldiv funct is ignored; concurrent mthi still lands
        Function_opcode = F_MFHI;
        Read_data_1 = 32'h0BADF00D;
        Read_data_2 = 32'd3;
        Start = 1'b1;
        Mthi = 1'b1;
        tick();
        Start = 1'b0;
        Mthi = 1'b0;
        check("bad_funct_busy", {31'd0, Busy}, 32'd0);
        check("bad_funct_mthi", Hi_out, 32'h0BADF00D);
        m_hi = 32'h0BADF00D;

        // Table-driven operations
        for (int i = 0; i < 15; i++) run_op(vecs[i]);

        // Accepted Start drops a simultaneous Mthi/Mtlo
        Function_opcode = F_MULTU;
        Read_data_1 = 32'd3;
        Read_data_2 = 32'd5;
        Start = 1'b1;
        Mthi = 1'b1;
        Mtlo = 1'b1;
        tick();
        Start = 1'b0;
        Mthi = 1'b0;
        Mtlo = 1'b0;
        check("start_drops_mthi", Hi_out, m_hi);
        check("start_drops_mtlo", Lo_out, m_lo);
        // Mid-CALC: second Start and Mthi pulse must both be ignored
        for (int n = 1; n < 6; n++) tick();
        Function_opcode = F_DIVU;
        Read_data_1 = 32'hDEADBEEF;
        Read_data_2 = 32'd9;
        Start = 1'b1;
        Mthi = 1'b1;
        tick();
        Start = 1'b0;
        Mthi = 1'b0;
        check("midcalc_hi_kept", Hi_out, m_hi);
        for (int n = 7; n < 34; n++) tick();
        check("midcalc_done", {31'd0, Done}, 32'd1);
        check("midcalc_hi", Hi_out, 32'd0);
        check("midcalc_lo", Lo_out, 32'd15);
        tick();
        check("midcalc_no_restart", {31'd0, Busy}, 32'd0);

        // Reset during CALC iteration 10 after preloading HI/LO
        Read_data_1 = 32'h11111111;
        Mthi = 1'b1;
        Mtlo = 1'b1;
        tick();
        Mthi = 1'b0;
        Mtlo = 1'b0;
        check("preload_hi", Hi_out, 32'h11111111);
        check("preload_lo", Lo_out, 32'h11111111);
        Function_opcode = F_MULT;
        Read_data_1 = 32'h00012345;
        Read_data_2 = 32'h00000777;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int n = 1; n < 11; n++) tick();
        check("pre_abort_busy", {31'd0, Busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        check("abort_hi", Hi_out, 32'h0);
        check("abort_lo", Lo_out, 32'h0);
        begin
            int seen_done;
            seen_done = 0;
            for (int n = 0; n < 40; n++) begin
                if (Done === 1'b1 || Busy === 1'b1) seen_done++;
                tick();
            end
            check("abort_quiet", 32'(seen_done), 32'd0);
        end
        check("abort_hi_final", Hi_out, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers; sits beside the execute stage and consumes the same rs/rt operands and function code.
- Replaces combinational mult/div with 32-iteration shift-add / restoring-divide datapaths. The ALU critical path stays short.
- Exposes Busy so the controller stalls dependent mfhi/mflo and further mult/div.
- Serves mthi/mtlo writes and mfhi/mflo reads through registered Hi_out/Lo_out.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; iteration count = WIDTH.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- Start  in  1  controller: R-type with funct mult/multu/div/divu in execute
- Function_opcode  in  6  instruction[5:0], sampled with Start
- Read_data_1  in  WIDTH  rs operand: multiplicand or dividend; also mthi/mtlo source
- Read_data_2  in  WIDTH  rt operand: multiplier or divisor
- Mthi  in  1  write Read_data_1 into HI
- Mtlo  in  1  write Read_data_1 into LO
- Hi_out  out  WIDTH  HI register
- Lo_out  out  WIDTH  LO register
- Busy  out  1  high whenever state != IDLE
- Done  out  1  one-cycle pulse in the first cycle new HI/LO are visible

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, HI=0, LO=0, Done=0, Busy=0, counter=0, internal operands=0.
- Reset mid-operation:
  - Aborts the operation.
  - Takes priority over every other input.
  - HI/LO are cleared, not partially updated.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - Start=1 with a funct in {0x18 mult, 0x19 multu, 0x1A div, 0x1B divu} latches the operation, operand magnitudes (signed ops) or raw values (unsigned ops), and result-sign flags.
  - On that latch, counter=0 and state goes to CALC.
  - Start with any other funct is ignored.
- CALC:
  - One iteration per cycle; counter increments; after iteration WIDTH-1, state goes to FIX.
  - Multiply: 2*WIDTH-bit shift-add product.
  - Divide: restoring, one quotient bit per cycle, MSB first.
- FIX:
  - Applies sign correction:
    - product negated if sign(a)^sign(b);
    - quotient negated if sign(a)^sign(b);
    - remainder takes the sign of the dividend.
  - Writes HI/LO, returns to IDLE, Done=1 for exactly that next cycle.
- Latency: HI/LO new values and Done=1 appear 34 clock edges after the edge that samples Start. Busy is high for the 33 cycles following the sampling edge.
- Results:
  - mult/multu: {HI,LO} = full 2*WIDTH product.
  - div/divu: LO = quotient, HI = remainder. Truncation toward zero.
- Divide by zero (Read_data_2=0 at Start):
  - No iteration; state goes to FIX directly.
  - Result: LO=all ones, HI=Read_data_1 as latched.
  - Done follows 2 edges after Start.
- Signed overflow (div 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0. This falls out naturally from magnitude arithmetic; no special case.
- Start while Busy: ignored. The controller must hold Start until Busy=0.
- Mthi/Mtlo:
  - In IDLE, they update the register on the next edge. Both may assert in the same cycle.
  - While Busy, they are ignored.
  - In the same cycle as an accepted Start, Start wins and Mthi/Mtlo are dropped.
- Hi_out/Lo_out: always reflect the registers. Intermediate CALC values never appear on them.
- No combinational path from any input to any output.

Decomposition:
- Shared package:
  - funct constants FUNCT_MULT=6'h18, FUNCT_MULTU=6'h19, FUNCT_DIV=6'h1A, FUNCT_DIVU=6'h1B, FUNCT_MFHI=6'h10, FUNCT_MTHI=6'h11, FUNCT_MFLO=6'h12, FUNCT_MTLO=6'h13;
  - state encoding IDLE/CALC/FIX.
- One sub-module, muldiv_iter_core: the unsigned iterative datapath (accumulator, shift register, counter, op select). The top keeps the FSM, sign handling, HI/LO registers and mt* writes.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> after 34 edges Done=1, HI=0xFFFFFFFE, LO=0x00000001; Busy high exactly 33 cycles.
- mult -3 x 7 (0xFFFFFFFD, 0x00000007) -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; divu 100/7 -> LO=14, HI=2.
- div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 7/-2 -> LO=0xFFFFFFFD, HI=0x00000001; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- div 0x1234/0 -> Done 2 edges after Start, LO=0xFFFFFFFF, HI=0x00001234.
- mthi 0xAAAA5555 then mtlo 0x5555AAAA in IDLE -> Hi_out/Lo_out update next edge. Second Start and Mthi pulsed mid-CALC -> both ignored; first result unaffected.
- reset asserted at CALC iteration 10 after HI/LO preloaded with 0x11111111 -> next edge state=IDLE, Busy=0, HI=LO=0, no Done pulse.
